// File: rtl/invsqrt_nr_scheduler.sv
// invsqrt_nr_scheduler: issue scheduler for the shared Newton-Raphson
// inverse-square-root pipeline. It seeds each operand with the magic
// constant and recirculates it ITERS times through the fixed-latency
// pipeline. A delay line aligned with the pipeline tracks the iteration
// count and tag of every slot.
// Optional build macro: SDUP_SCHED_CHECK_EN. When it is defined, ret_valid
// is checked against the delay line, mismatches set a sticky err, and
// returns that have no matching slot are dropped.
module invsqrt_nr_scheduler #(
  parameter int PIPE_LAT = 4,
  parameter int ITERS    = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [30:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             pipe_valid,
  output logic [30:0]      pipe_x,
  output logic [30:0]      pipe_y,
  input  logic             ret_valid,
  input  logic [30:0]      ret_x,
  input  logic [30:0]      ret_y,
  output logic             out_valid,
  output logic [30:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err
);

  typedef struct packed {
    logic             v;
    logic [2:0]       it;
    logic [TAG_W-1:0] tag;
  } slot_t;

  localparam logic [2:0] LAST_IT = 3'(ITERS - 1);

  // dl[PIPE_LAT] lines up with the cycle in which ret_valid arrives
  slot_t [PIPE_LAT:0] dl;
  slot_t              last;
  logic               ret_ok, recirc, retire, accept;
  logic [30:0]        seed;
  logic               unused_lsb;

  assign last = dl[PIPE_LAT];

  // The seed uses x >> 1, so the mantissa LSB never contributes
  assign unused_lsb = in_x[0];
  assign seed       = 31'h5F3759DF - {1'b0, in_x[30:1]};

`ifdef SDUP_SCHED_CHECK_EN
  assign ret_ok = ret_valid & last.v;
`else
  assign ret_ok = ret_valid;
`endif

  // A recirculation takes the issue slot, so a new request is refused
  // in any cycle where a non-final return arrives.
  assign in_ready = !(ret_valid && (last.it < LAST_IT));
  assign recirc   = ret_ok && (last.it < LAST_IT);
  assign retire   = ret_ok && (last.it == LAST_IT);
  assign accept   = in_valid && in_ready;

  // Issue register: a recirculation wins over a new operand; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_x     <= '0;
      pipe_y     <= '0;
    end else begin
      pipe_valid <= recirc | accept;
      if (recirc) begin
        pipe_x <= ret_x;
        pipe_y <= ret_y;
      end else if (accept) begin
        pipe_x <= in_x;
        pipe_y <= seed;
      end
    end
  end

  // Slot delay line: stage 0 is loaded together with the issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl <= '0;
    end else begin
      if (recirc)      dl[0] <= '{v: 1'b1, it: last.it + 3'd1, tag: last.tag};
      else if (accept) dl[0] <= '{v: 1'b1, it: 3'd0, tag: in_tag};
      else             dl[0] <= '0;
      for (int k = 1; k <= PIPE_LAT; k++) dl[k] <= dl[k-1];
    end
  end

  // Result register: one-cycle strobe on the final return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= retire;
      if (retire) begin
        out_y   <= ret_y;
        out_tag <= last.tag;
      end
    end
  end

`ifdef SDUP_SCHED_CHECK_EN
  // Sticky flag: a return without a slot, or a slot without a return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err <= 1'b0;
    else if (ret_valid != last.v) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  // Anything in flight, whether in the issue register or in the delay line
  always_comb begin
    busy = pipe_valid;
    for (int k = 0; k <= PIPE_LAT; k++) busy = busy | dl[k].v;
  end

endmodule
